// File: rtl/sample_checker.sv
// AXI4-Stream slave that checks an incrementing count stream and its TLAST framing.
// Exposes saturating error/beat/packet counters and sticky error flags.
module sample_checker #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH = 32,
    parameter int unsigned C_CNT_WIDTH         = 32
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               enable,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     tlast_throttle,
    input  logic                               clear_status,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    input  logic                               S_AXIS_TLAST,
    input  logic                               S_AXIS_TVALID,
    output logic                               S_AXIS_TREADY,
    output logic                               locked,
    output logic [C_CNT_WIDTH-1:0]             seq_error_count,
    output logic [C_CNT_WIDTH-1:0]             tlast_error_count,
    output logic [C_CNT_WIDTH-1:0]             beat_count,
    output logic [C_CNT_WIDTH-1:0]             packet_count,
    output logic                               seq_error_sticky,
    output logic                               tlast_error_sticky
);

    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned CW = C_CNT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t         state;
    logic [DW-1:0]  expected;
    logic [DW-1:0]  beat_idx;
    logic           miss;

    logic           accept;
    logic [DW-1:0]  last_limit;
    logic           last_exp;
    logic           data_match;
    logic           unused_keep;

    assign unused_keep = ^S_AXIS_TKEEP;

    // A throttle of 0 behaves like 1, so the last beat index is 0 in both cases.
    assign accept     = S_AXIS_TVALID && S_AXIS_TREADY;
    assign last_limit = (tlast_throttle == '0) ? '0 : tlast_throttle - DW'(1);
    assign last_exp   = (beat_idx == last_limit);
    assign data_match = (S_AXIS_TDATA == expected);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state              <= ST_IDLE;
            expected           <= '0;
            beat_idx           <= '0;
            miss               <= 1'b0;
            S_AXIS_TREADY      <= 1'b0;
            locked             <= 1'b0;
            seq_error_count    <= '0;
            tlast_error_count  <= '0;
            beat_count         <= '0;
            packet_count       <= '0;
            seq_error_sticky   <= 1'b0;
            tlast_error_sticky <= 1'b0;
        end else begin
            S_AXIS_TREADY <= enable;

            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (accept) begin
                        expected <= S_AXIS_TDATA + DW'(1);
                        if (S_AXIS_TLAST) begin
                            state    <= ST_CHECK;
                            beat_idx <= '0;
                            locked   <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        beat_count <= sat_inc(beat_count);

                        // One miss skips ahead by one; a second consecutive miss relocks on the data.
                        if (data_match) begin
                            expected <= S_AXIS_TDATA + DW'(1);
                            miss     <= 1'b0;
                        end else begin
                            seq_error_count  <= sat_inc(seq_error_count);
                            seq_error_sticky <= 1'b1;
                            if (!miss) begin
                                expected <= expected + DW'(1);
                                miss     <= 1'b1;
                            end else begin
                                expected <= S_AXIS_TDATA + DW'(1);
                                miss     <= 1'b0;
                            end
                        end

                        if (S_AXIS_TLAST != last_exp) begin
                            tlast_error_count  <= sat_inc(tlast_error_count);
                            tlast_error_sticky <= 1'b1;
                        end
                        if (S_AXIS_TLAST || last_exp) beat_idx <= '0;
                        else                          beat_idx <= beat_idx + DW'(1);
                        if (S_AXIS_TLAST) packet_count <= sat_inc(packet_count);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (!enable) begin
                state  <= ST_IDLE;
                locked <= 1'b0;
            end

            if (clear_status) begin
                seq_error_count    <= '0;
                tlast_error_count  <= '0;
                beat_count         <= '0;
                packet_count       <= '0;
                seq_error_sticky   <= 1'b0;
                tlast_error_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_checker.sv
// Bench for sample_checker: directed scenarios plus randomized stream against a behavioural model.
module tb_sample_checker;

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 8;
    localparam longint      CMAX = 255;

    logic            ACLK;
    logic            ARESETN;
    logic            enable;
    logic [DW-1:0]   tlast_throttle;
    logic            clear_status;
    logic [DW-1:0]   S_AXIS_TDATA;
    logic [DW/8-1:0] S_AXIS_TKEEP;
    logic            S_AXIS_TLAST;
    logic            S_AXIS_TVALID;
    logic            S_AXIS_TREADY;
    logic            locked;
    logic [CW-1:0]   seq_error_count;
    logic [CW-1:0]   tlast_error_count;
    logic [CW-1:0]   beat_count;
    logic [CW-1:0]   packet_count;
    logic            seq_error_sticky;
    logic            tlast_error_sticky;

    sample_checker #(.C_S_AXIS_DATA_WIDTH(DW), .C_CNT_WIDTH(CW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .tlast_throttle(tlast_throttle),
        .clear_status(clear_status), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .locked(locked), .seq_error_count(seq_error_count), .tlast_error_count(tlast_error_count),
        .beat_count(beat_count), .packet_count(packet_count),
        .seq_error_sticky(seq_error_sticky), .tlast_error_sticky(tlast_error_sticky)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode;          // 0 idle, 1 hunting for TLAST, 2 checking
    bit          m_rdy, m_locked, m_miss, m_ss, m_ts;
    bit [DW-1:0] m_exp;
    longint      m_idx, m_seq, m_tl, m_beat, m_pkt;

    function automatic longint inc(input longint v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_rdy = 0; m_locked = 0; m_miss = 0; m_ss = 0; m_ts = 0;
        m_exp = '0; m_idx = 0; m_seq = 0; m_tl = 0; m_beat = 0; m_pkt = 0;
    endtask

    task automatic model_step();
        bit     acc;
        int     cur;
        longint thr;
        bit     lx;
        acc = S_AXIS_TVALID && m_rdy;
        cur = m_mode;
        if (acc && cur == 1) begin
            m_exp = S_AXIS_TDATA + DW'(1);
            if (S_AXIS_TLAST) begin m_mode = 2; m_idx = 0; m_locked = 1; end
        end
        if (acc && cur == 2) begin
            thr = (tlast_throttle == 0) ? 1 : longint'(tlast_throttle);
            lx  = (m_idx == thr - 1);
            m_beat = inc(m_beat);
            if (S_AXIS_TDATA == m_exp) begin
                m_exp = S_AXIS_TDATA + DW'(1); m_miss = 0;
            end else begin
                m_seq = inc(m_seq); m_ss = 1;
                if (!m_miss) begin m_exp = m_exp + DW'(1); m_miss = 1; end
                else         begin m_exp = S_AXIS_TDATA + DW'(1); m_miss = 0; end
            end
            if (S_AXIS_TLAST != lx) begin m_tl = inc(m_tl); m_ts = 1; end
            m_idx = (S_AXIS_TLAST || lx) ? 0 : m_idx + 1;
            if (S_AXIS_TLAST) m_pkt = inc(m_pkt);
        end
        if (cur == 0 && enable) m_mode = 1;
        if (!enable) begin m_mode = 0; m_locked = 0; end
        if (clear_status) begin
            m_seq = 0; m_tl = 0; m_beat = 0; m_pkt = 0; m_ss = 0; m_ts = 0;
        end
        m_rdy = enable;
    endtask

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) model_reset();
        else          model_step();
    end

    // Every cycle out of reset, all outputs must match the model.
    always @(negedge ACLK) begin
        if (cmp_en && ARESETN) begin
            chk("tready",       S_AXIS_TREADY,      m_rdy);
            chk("locked",       locked,             m_locked);
            chk("seq_err_cnt",  seq_error_count,    m_seq);
            chk("tlast_err_cnt",tlast_error_count,  m_tl);
            chk("beat_cnt",     beat_count,         m_beat);
            chk("pkt_cnt",      packet_count,       m_pkt);
            chk("seq_sticky",   seq_error_sticky,   m_ss);
            chk("tlast_sticky", tlast_error_sticky, m_ts);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit [DW-1:0] g_val;
    int          g_idx;
    int          g_thr;

    task automatic check_all_zero(input string tag);
        chk({tag, "_tready"}, S_AXIS_TREADY, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_seq"},    seq_error_count, 0);
        chk({tag, "_tl"},     tlast_error_count, 0);
        chk({tag, "_beat"},   beat_count, 0);
        chk({tag, "_pkt"},    packet_count, 0);
        chk({tag, "_ss"},     seq_error_sticky, 0);
        chk({tag, "_ts"},     tlast_error_sticky, 0);
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit l);
        bit r;
        int guard;
        guard = 0;
        S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = d; S_AXIS_TLAST = l;
        forever begin
            r = S_AXIS_TREADY;
            @(posedge ACLK); #1;
            if (r) break;
            guard++;
            if (guard > 50) begin
                total++; bad++;
                $display("FAIL beat_timeout: got no ready expected ready within 50 cycles");
                break;
            end
        end
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic clean(input int n);
        repeat (n) begin
            beat(g_val, g_idx == g_thr - 1);
            g_val = g_val + DW'(1);
            g_idx = (g_idx == g_thr - 1) ? 0 : g_idx + 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint saved;
        bit     r, v, acc, hold, tl, clr_pulse;
        bit [DW-1:0] nxt_val, d;
        int     nxt_idx, thr_eff, rr;

        ARESETN = 0; enable = 0; tlast_throttle = 4; clear_status = 0;
        S_AXIS_TDATA = '0; S_AXIS_TKEEP = '1; S_AXIS_TLAST = 0; S_AXIS_TVALID = 0;
        g_val = '0; g_idx = 0; g_thr = 4;
        #12;
        check_all_zero("reset");
        @(negedge ACLK); #3 ARESETN = 1;
        @(posedge ACLK); #1;
        cmp_en = 1; enable = 1;

        // Clean stream 0..19, throttle 4: SYNC eats 0..3
        clean(20);
        chk("s1_locked", locked, 1);
        chk("s1_beat", beat_count, 16);
        chk("s1_pkt", packet_count, 4);
        chk("s1_seq", seq_error_count, 0);
        chk("s1_tl", tlast_error_count, 0);

        // Single corrupted beat (value-2) counts one error
        clean(2);
        beat(g_val - DW'(2), g_idx == g_thr - 1);
        g_val = g_val + DW'(1); g_idx = (g_idx == g_thr - 1) ? 0 : g_idx + 1;
        clean(4);
        chk("s2_seq", seq_error_count, 1);
        chk("s2_sticky", seq_error_sticky, 1);

        // Dropped beat counts two errors then relocks
        g_val = g_val + DW'(1);
        clean(6);
        chk("s3_seq", seq_error_count, 3);
        chk("s3_tl", tlast_error_count, 0);

        // Framing: TLAST missing on 4th beat, present on 6th
        clean((4 - g_idx) % 4);
        saved = m_pkt;
        for (int i = 0; i < 6; i++) begin
            beat(g_val, i == 5);
            g_val = g_val + DW'(1);
        end
        chk("s4_tl", tlast_error_count, 2);
        chk("s4_pkt", packet_count, saved + 1);
        clean(8);
        chk("s4_tl_realign", tlast_error_count, 2);

        // Jump near all-ones, clear, then wrap through zero
        g_val = 32'hFFFF_FFFA;
        clean(3);
        clear_status = 1; @(posedge ACLK); #1; clear_status = 0;
        chk("s5_clr_seq", seq_error_count, 0);
        clean(8);
        chk("s5_wrap_seq", seq_error_count, 0);
        chk("s5_wrap_ss", seq_error_sticky, 0);

        // Clear on the same cycle as a bad beat wins
        clear_status = 1;
        beat(g_val + DW'(5), g_idx == g_thr - 1);
        clear_status = 0;
        g_val = g_val + DW'(1); g_idx = (g_idx == g_thr - 1) ? 0 : g_idx + 1;
        chk("s5_clr_seq2", seq_error_count, 0);
        chk("s5_clr_beat", beat_count, 0);
        chk("s5_clr_ss", seq_error_sticky, 0);
        clean(1);

        // enable falls mid-packet with TVALID high: that beat is still processed
        S_AXIS_TVALID = 1; S_AXIS_TDATA = g_val; S_AXIS_TLAST = (g_idx == g_thr - 1);
        enable = 0;
        @(posedge ACLK); #1;
        g_val = g_val + DW'(1); g_idx = (g_idx == g_thr - 1) ? 0 : g_idx + 1;
        chk("s6_tready", S_AXIS_TREADY, 0);
        chk("s6_locked", locked, 0);
        chk("s6_beat", beat_count, 2);
        saved = m_beat;
        S_AXIS_TDATA = g_val; S_AXIS_TLAST = (g_idx == g_thr - 1);
        repeat (3) @(posedge ACLK);
        #1;
        chk("s6_held", beat_count, saved);
        S_AXIS_TVALID = 0;
        enable = 1;
        clean(10);
        chk("s6_relocked", locked, 1);

        // Asynchronous reset mid-packet
        @(posedge ACLK); #3 ARESETN = 0;
        #1 check_all_zero("areset");
        #3 ARESETN = 1;
        @(posedge ACLK); #1;
        clean(12);
        chk("s7_relocked", locked, 1);

        // Randomized phase
        hold = 0; clr_pulse = 0; nxt_val = g_val; nxt_idx = g_idx;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (clr_pulse) begin clear_status = 0; clr_pulse = 0; end
            if ($urandom_range(0, 249) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 9) == 0) enable = 1;
            if ($urandom_range(0, 699) == 0) begin clear_status = 1; clr_pulse = 1; end
            if ($urandom_range(0, 199) == 0) begin
                tlast_throttle = DW'($urandom_range(0, 6));
                g_thr = (tlast_throttle == 0) ? 1 : int'(tlast_throttle);
            end
            if (!hold) begin
                thr_eff = g_thr;
                rr = $urandom_range(0, 59);
                if (rr == 0)      begin d = g_val ^ (DW'(1) << $urandom_range(0, DW-1)); nxt_val = g_val + DW'(1); end
                else if (rr == 1) begin d = g_val + DW'(1); nxt_val = g_val + DW'(2); end
                else if (rr == 2) begin d = g_val - DW'(1); nxt_val = g_val; end
                else              begin d = g_val; nxt_val = g_val + DW'(1); end
                tl = (g_idx >= thr_eff - 1);
                if ($urandom_range(0, 49) == 0) tl = ~tl;
                nxt_idx = tl ? 0 : g_idx + 1;
                S_AXIS_TDATA = d; S_AXIS_TLAST = tl;
                S_AXIS_TVALID = ($urandom_range(0, 3) != 0);
            end
            r = S_AXIS_TREADY; v = S_AXIS_TVALID;
            if ($urandom_range(0, 1499) == 0) begin
                #2 ARESETN = 0;
                #3 ARESETN = 1;
                @(posedge ACLK); #1;
                acc = 0;
            end else begin
                @(posedge ACLK); #1;
                acc = r && v;
            end
            if (acc) begin g_val = nxt_val; g_idx = nxt_idx; end
            hold = v && !acc && ARESETN;
        end
        clear_status = 0;
        S_AXIS_TVALID = 0;
        repeat (3) @(posedge ACLK);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_checker.md
Name: sample_checker

Overview:
AXI4-Stream slave that consumes the count-data stream from the PL sample generator and verifies it in hardware. It checks the incrementing-by-one data sequence and the TLAST framing against a programmable packet length. It exposes saturating error, beat and packet counters plus sticky flags, so software or a loopback bench can confirm DMA-cyclic integrity and the sample generator's error-insertion path.

Parameters:
C_S_AXIS_DATA_WIDTH, 32, stream data width; also the width of tlast_throttle.
C_CNT_WIDTH, 32, width of every status counter.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESETN  in  1  asynchronous, active-low reset.
enable  in  1  1 = accept and check the stream.
tlast_throttle  in  C_S_AXIS_DATA_WIDTH  beats per packet; 0 is treated as 1.
clear_status  in  1  synchronous clear of counters and sticky flags.
S_AXIS_TDATA  in  C_S_AXIS_DATA_WIDTH  stream data.
S_AXIS_TKEEP  in  C_S_AXIS_DATA_WIDTH/8  ignored.
S_AXIS_TLAST  in  1  packet end.
S_AXIS_TVALID  in  1  beat valid.
S_AXIS_TREADY  out  1  registered ready.
locked  out  1  1 while in CHECK.
seq_error_count  out  C_CNT_WIDTH  data mismatches.
tlast_error_count  out  C_CNT_WIDTH  framing mismatches.
beat_count  out  C_CNT_WIDTH  beats checked.
packet_count  out  C_CNT_WIDTH  TLAST beats checked.
seq_error_sticky  out  1  set on any data mismatch.
tlast_error_sticky  out  1  set on any framing mismatch.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; expected and beat_idx 0; miss flag 0.
- Accept = S_AXIS_TVALID && S_AXIS_TREADY. Only accepted beats have any effect.
- S_AXIS_TREADY <= enable every cycle, so it follows enable with 1-cycle latency. A beat accepted in the cycle enable falls is still processed.
- State IDLE: if enable, go to SYNC.
- State SYNC: on each accept, expected <= TDATA+1. An accept with TLAST moves the block to CHECK, with beat_idx <= 0 and locked <= 1 on the next cycle. Beats in SYNC are not counted or checked.
- State CHECK, per accept:
  - beat_count++.
  - Data check: compare TDATA against expected.
    - Match: expected <= TDATA+1 and miss <= 0.
    - Mismatch with miss=0: seq_error_count++, seq_error_sticky <= 1, expected <= expected+1, miss <= 1.
    - Mismatch with miss=1: seq_error_count++, expected <= TDATA+1 (relock), miss <= 0.
    - Result: a single corrupted beat counts 1 error; a dropped or duplicated beat counts 2 errors and then relocks.
  - Framing check: last_exp = (beat_idx == max(tlast_throttle,1)-1).
    - If TLAST != last_exp: tlast_error_count++ and tlast_error_sticky <= 1.
    - If TLAST or last_exp: beat_idx <= 0; otherwise beat_idx++.
    - If TLAST: packet_count++.
- Any state: enable=0 → next state IDLE and locked <= 0. Counters and flags are held.
- Arithmetic:
  - Data compare and expected update wrap modulo 2^C_S_AXIS_DATA_WIDTH, so all-ones followed by 0 is a match.
  - Counters saturate at all-ones.
  - tlast_throttle is sampled every beat; a mid-packet change takes effect immediately.
- clear_status=1 zeroes all counters and sticky flags and has priority over a same-cycle increment. It does not change state, expected, beat_idx or locked.
- Reset mid-packet: returns to IDLE; the block must resync on the next TLAST after enable.

Test Plan:
- Throttle 4, enable=1, clean stream 0..19 with TLAST on 3,7,11,15,19 → SYNC consumes 0..3; locked=1; beat_count=16, packet_count=4, both error counts 0.
- Locked stream expecting 10, beat value 8 (generator error insertion: sample−2), then 11,12 → seq_error_count=1, sticky=1, relocked with no further errors.
- Locked stream expecting 20, beat 20 dropped (21,22,23 sent) → seq_error_count=2, then 0 errors from 23 onward.
- Throttle 4, TLAST missing on a packet's 4th beat and present on its 6th → tlast_error_count=2, packet_count counts only the TLAST beat; framing then realigns.
- Data wraps from 0xFFFFFFFF to 0x00000000 while locked → no error. Then pulse clear_status on the same cycle as a bad beat → all counters 0 and flags 0.
- enable falls mid-packet with TVALID held high → TREADY low 1 cycle later, locked=0, counters held. Re-enable → SYNC discards beats up to the next TLAST. Assert ARESETN low asynchronously → all outputs 0 immediately.
